// File: rtl/return_address_stack_pkg.sv
// Shared types and constants for the return address stack.
//   ras_op_t   : stack action derived from a control-transfer instruction
//   RAS_LINK1/2: the two RISC-V link registers (ra = x1, t0 = x5)
//   OP_JAL/JALR: rv32i opcodes that can touch the stack
//   is_link()  : true when a register index names a link register
package return_address_stack_pkg;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_t;

  localparam logic [4:0] RAS_LINK1 = 5'd1;
  localparam logic [4:0] RAS_LINK2 = 5'd5;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic is_link(input logic [4:0] r);
    return (r == RAS_LINK1) || (r == RAS_LINK2);
  endfunction

endpackage

// File: rtl/ras_classify.sv
// Combinational classification of one instruction into a stack action.
//   opcode : rv32i opcode
//   rd     : destination register
//   rs1    : base register
//   op     : RAS_NONE / RAS_PUSH / RAS_POP / RAS_POPPUSH
// JALR with rd == rs1 (both link) is a plain push; JALR with two different
// link registers swaps the top entry (pop-push).
module ras_classify
  import return_address_stack_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  output ras_op_t    op
);

  logic rd_link;
  logic rs1_link;

  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  always_comb begin
    op = RAS_NONE;
    if (opcode == OP_JAL) begin
      if (rd_link) op = RAS_PUSH;
    end else if (opcode == OP_JALR) begin
      if (rd_link && rs1_link && (rd != rs1)) op = RAS_POPPUSH;
      else if (rd_link)                       op = RAS_PUSH;
      else if (rs1_link)                      op = RAS_POP;
    end
  end

endmodule

// File: rtl/return_address_stack.sv
// Return address stack predicting JALR return targets for the next-PC mux.
// Speculatively updated from decode; a shadow pointer pair tracks the
// architecturally committed stack from execute and repairs tos/cnt on flush.
//   clk, rst_n             : clock, synchronous active-low reset
//   dec_valid/dec_stall    : decode slot qualifiers
//   dec_pc/opcode/rd/rs1   : decode instruction fields
//   exe_valid              : execute instruction advancing this cycle
//   exe_pc/opcode/rd/rs1   : execute instruction fields (pc unused: pointers only)
//   flush                  : execute redirect
//   ras_hit, ras_target    : combinational return prediction for decode
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic        dec_stall,
  input  logic [31:0] dec_pc,
  input  logic [6:0]  dec_opcode,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic        exe_valid,
  input  logic [31:0] exe_pc,
  input  logic [6:0]  exe_opcode,
  input  logic [4:0]  exe_rd,
  input  logic [4:0]  exe_rs1,
  input  logic        flush,
  output logic        ras_hit,
  output logic [31:0] ras_target
);

  localparam int unsigned CNT_W = PTR_W + 1;

  ras_op_t dec_op;
  ras_op_t exe_op;

  logic [PTR_W-1:0] tos_q,   tos_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PTR_W-1:0] s_tos_q, s_tos_d;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  logic             dec_upd;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             unused_exe_pc;

  assign unused_exe_pc = ^exe_pc;

  ras_classify u_dec_classify (
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .op     (dec_op)
  );

  ras_classify u_exe_classify (
    .opcode (exe_opcode),
    .rd     (exe_rd),
    .rs1    (exe_rs1),
    .op     (exe_op)
  );

  // Pop-push on an empty stack has nothing to replace, so it degrades to a push.
  function automatic logic is_push(input ras_op_t op, input logic [CNT_W-1:0] cnt);
    return (op == RAS_PUSH) || ((op == RAS_POPPUSH) && (cnt == '0));
  endfunction

  function automatic logic [PTR_W-1:0] next_tos(input ras_op_t op,
                                                input logic [PTR_W-1:0] tos,
                                                input logic [CNT_W-1:0] cnt);
    if (is_push(op, cnt))                      return tos + PTR_W'(1);
    else if ((op == RAS_POP) && (cnt != '0))   return tos - PTR_W'(1);
    else                                       return tos;
  endfunction

  // Saturates at DEPTH: an overflowing push overwrites the oldest slot.
  function automatic logic [CNT_W-1:0] next_cnt(input ras_op_t op,
                                                input logic [CNT_W-1:0] cnt);
    if (is_push(op, cnt))                      return (cnt == CNT_W'(DEPTH)) ? cnt : cnt + CNT_W'(1);
    else if ((op == RAS_POP) && (cnt != '0))   return cnt - CNT_W'(1);
    else                                       return cnt;
  endfunction

  assign ras_hit    = dec_valid & ((dec_op == RAS_POP) | (dec_op == RAS_POPPUSH))
                    & (cnt_q != '0) & ~flush;
  assign ras_target = ras_hit ? data_q[tos_q] : '0;

  assign dec_upd = dec_valid & ~dec_stall & ~flush;
  assign wr_en   = dec_upd & ((dec_op == RAS_PUSH) | (dec_op == RAS_POPPUSH));
  assign wr_idx  = is_push(dec_op, cnt_q) ? tos_q + PTR_W'(1) : tos_q;

  always_comb begin
    s_tos_d = s_tos_q;
    s_cnt_d = s_cnt_q;
    if (exe_valid) begin
      s_tos_d = next_tos(exe_op, s_tos_q, s_cnt_q);
      s_cnt_d = next_cnt(exe_op, s_cnt_q);
    end
  end

  // Flush repairs from the shadow value that already includes this cycle's exe update.
  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    if (flush) begin
      tos_d = s_tos_d;
      cnt_d = s_cnt_d;
    end else if (dec_upd) begin
      tos_d = next_tos(dec_op, tos_q, cnt_q);
      cnt_d = next_cnt(dec_op, cnt_q);
    end
  end

  always_comb begin
    data_d = data_q;
    if (wr_en) data_d[wr_idx] = dec_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tos_q   <= '0;
      cnt_q   <= '0;
      s_tos_q <= '0;
      s_cnt_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      tos_q   <= tos_d;
      cnt_q   <= cnt_d;
      s_tos_q <= s_tos_d;
      s_cnt_q <= s_cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;

  localparam logic [6:0] JAL  = 7'h6F;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [6:0] ADD  = 7'h33;
  localparam int         D    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0, dec_stall = 1'b0;
  logic [31:0] dec_pc = '0;
  logic [6:0]  dec_opcode = '0;
  logic [4:0]  dec_rd = '0, dec_rs1 = '0;
  logic        exe_valid = 1'b0;
  logic [31:0] exe_pc = '0;
  logic [6:0]  exe_opcode = '0;
  logic [4:0]  exe_rd = '0, exe_rs1 = '0;
  logic        flush = 1'b0;
  logic        ras_hit;
  logic [31:0] ras_target;

  always #5 clk = ~clk;

  return_address_stack #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_stall(dec_stall), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_opcode(exe_opcode),
    .exe_rd(exe_rd), .exe_rs1(exe_rs1), .flush(flush),
    .ras_hit(ras_hit), .ras_target(ras_target)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stack as a circular array with a top index and an occupancy count.
  int unsigned m_data [D];
  int          m_tos, m_cnt, m_stos, m_scnt;

  // 0 none, 1 push, 2 pop, 3 pop-push
  function automatic int kind(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1);
    bit lrd, lrs, call, ret, swap;
    lrd  = (rd == 5'd1) || (rd == 5'd5);
    lrs  = (rs1 == 5'd1) || (rs1 == 5'd5);
    call = ((opc == JAL) || (opc == JALR)) && lrd;
    ret  = (opc == JALR) && lrs && !lrd;
    swap = (opc == JALR) && lrd && lrs && (rd != rs1);
    if (swap) return 3;
    if (call) return 1;
    if (ret)  return 2;
    return 0;
  endfunction

  task automatic ptr_step(input int k, inout int t, inout int c);
    if (k == 1 || (k == 3 && c == 0)) begin
      t = (t + 1) % D;
      c = (c < D) ? c + 1 : D;
    end else if (k == 2 && c > 0) begin
      t = (t + D - 1) % D;
      c = c - 1;
    end
  endtask

  always @(posedge clk) begin
    int k, st, sc;
    if (!rst_n) begin
      m_tos = 0; m_cnt = 0; m_stos = 0; m_scnt = 0;
      for (int i = 0; i < D; i++) m_data[i] = 0;
    end else begin
      st = m_stos; sc = m_scnt;
      if (exe_valid) ptr_step(kind(exe_opcode, exe_rd, exe_rs1), st, sc);
      if (flush) begin
        m_tos = st; m_cnt = sc;
      end else if (dec_valid && !dec_stall) begin
        k = kind(dec_opcode, dec_rd, dec_rs1);
        if (k == 3 && m_cnt > 0) m_data[m_tos] = dec_pc + 32'd4;
        else begin
          ptr_step(k, m_tos, m_cnt);
          if (k == 1 || k == 3) m_data[m_tos] = dec_pc + 32'd4;
        end
      end
      m_stos = st; m_scnt = sc;
    end
  end

  // Every-cycle compare of the outputs against the model.
  always @(negedge clk) begin
    int k;
    bit eh;
    logic [31:0] et;
    if (checking) begin
      k  = kind(dec_opcode, dec_rd, dec_rs1);
      eh = dec_valid && !flush && (k == 2 || k == 3) && (m_cnt != 0);
      et = eh ? m_data[m_tos] : 32'd0;
      chk("model_hit", {31'd0, ras_hit}, {31'd0, eh});
      chk("model_target", ras_target, et);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_stall = 0; exe_valid = 0; flush = 0;
    dec_opcode = ADD; exe_opcode = ADD;
  endtask

  task automatic dec(input logic [31:0] pc, input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1);
    dec_valid = 1; dec_pc = pc; dec_opcode = opc; dec_rd = rd; dec_rs1 = rs1;
  endtask

  task automatic exe(input logic [31:0] pc, input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1);
    exe_valid = 1; exe_pc = pc; exe_opcode = opc; exe_rd = rd; exe_rs1 = rs1;
  endtask

  task automatic lit(input string name, input logic hit, input logic [31:0] tgt);
    @(negedge clk);
    chk({name, "_hit"}, {31'd0, ras_hit}, {31'd0, hit});
    chk({name, "_target"}, ras_target, tgt);
  endtask

  task automatic mix(input bit dv, input bit ds, input logic [31:0] pc, input logic [6:0] opc,
                     input logic [4:0] rd, input logic [4:0] rs1, input bit ev,
                     input logic [6:0] eopc, input logic [4:0] erd, input logic [4:0] ers1, input bit fl);
    dec_valid = dv; dec_stall = ds; dec_pc = pc; dec_opcode = opc; dec_rd = rd; dec_rs1 = rs1;
    exe_valid = ev; exe_pc = pc - 32'd8; exe_opcode = eopc; exe_rd = erd; exe_rs1 = ers1;
    flush = fl;
    tick();
  endtask

  initial begin
    idle();
    tick(); tick();
    checking = 1;
    // Reset wins over a concurrent call and flush.
    dec(32'h50, JAL, 5'd1, 5'd0); flush = 1;
    lit("reset", 1'b0, 32'h0);
    tick();
    rst_n = 1; idle();

    // Return on an empty stack.
    dec(32'h100, JALR, 5'd0, 5'd1);
    lit("empty_ret", 1'b0, 32'h0);
    tick();
    chk("empty_cnt", m_cnt, 0);

    // Call then return.
    dec(32'h200, JAL, 5'd1, 5'd0); tick();
    dec(32'h204, JALR, 5'd0, 5'd1);
    lit("call_ret", 1'b1, 32'h204);
    tick();
    chk("call_ret_cnt", m_cnt, 0);

    // Nine calls overflow an 8-deep stack; the oldest (0x1004) is lost.
    for (int i = 0; i < 9; i++) begin
      dec(32'h1000 + 32'(16 * i), JAL, 5'd1, 5'd0); tick();
    end
    chk("ovf_cnt", m_cnt, 8);
    // Eight returns drain it; the ninth finds it empty and is not predicted.
    for (int i = 0; i < 9; i++) begin
      dec(32'h2000 + 32'(4 * i), JALR, 5'd0, 5'd1);
      if (i < 8) lit($sformatf("ovf_ret%0d", i), 1'b1, 32'h1084 - 32'(16 * i));
      else       lit("ovf_ret8", 1'b0, 32'h0);
      tick();
    end

    rst_n = 0; idle(); tick(); rst_n = 1;

    // Speculative push squashed by flush; pointers return to the shadow copy.
    dec(32'h500, JAL, 5'd1, 5'd0); tick();
    idle(); exe(32'h500, JAL, 5'd1, 5'd0); tick();
    idle(); dec(32'h300, JAL, 5'd1, 5'd0); tick();
    idle(); exe(32'h304, ADD, 5'd1, 5'd2); flush = 1; dec(32'h310, JALR, 5'd0, 5'd1);
    lit("flush", 1'b0, 32'h0);
    tick();
    chk("flush_cnt", m_cnt, 1);
    idle();
    // Pop-push: predicts old top, replaces it with its own link.
    dec(32'h400, JALR, 5'd1, 5'd5);
    lit("poppush", 1'b1, 32'h504);
    tick();
    chk("poppush_cnt", m_cnt, 1);
    dec(32'h700, JALR, 5'd0, 5'd1);
    lit("after_pp", 1'b1, 32'h404);
    tick();
    dec(32'h704, JALR, 5'd0, 5'd1);
    lit("after_pp_empty", 1'b0, 32'h0);
    tick();

    // Call held by stall for three cycles pushes exactly once.
    idle(); dec(32'h800, JAL, 5'd1, 5'd0); dec_stall = 1;
    tick(); tick(); tick();
    dec_stall = 0; tick();
    idle(); tick();
    chk("stall_cnt", m_cnt, 1);
    dec(32'h900, JALR, 5'd0, 5'd1);
    lit("stall_ret", 1'b1, 32'h804);
    tick();
    dec(32'h904, JALR, 5'd0, 5'd1);
    lit("stall_ret2", 1'b0, 32'h0);
    tick();

    // Mixed decode/execute/flush traffic, checked by the model each cycle.
    mix(1, 0, 32'hA00, JAL,  5'd5, 5'd0, 0, ADD,  5'd0, 5'd0, 0);
    mix(1, 0, 32'hA10, JALR, 5'd1, 5'd1, 1, JAL,  5'd5, 5'd0, 0);
    mix(1, 0, 32'hA20, JALR, 5'd5, 5'd1, 1, JALR, 5'd1, 5'd1, 0);
    mix(1, 0, 32'hA30, JALR, 5'd0, 5'd5, 1, JALR, 5'd5, 5'd1, 0);
    mix(1, 1, 32'hA40, JALR, 5'd0, 5'd1, 1, JALR, 5'd0, 5'd5, 0);
    mix(1, 0, 32'hA50, JALR, 5'd0, 5'd1, 0, ADD,  5'd0, 5'd0, 0);
    mix(1, 0, 32'hA60, JAL,  5'd1, 5'd0, 1, JAL,  5'd0, 5'd0, 1);
    mix(1, 0, 32'hA70, JALR, 5'd0, 5'd5, 1, JALR, 5'd0, 5'd1, 0);
    mix(1, 0, 32'hA80, JALR, 5'd5, 5'd1, 0, ADD,  5'd0, 5'd0, 0);
    mix(0, 0, 32'hA90, JALR, 5'd0, 5'd1, 1, JAL,  5'd1, 5'd0, 1);
    mix(1, 0, 32'hAA0, JALR, 5'd0, 5'd1, 0, ADD,  5'd0, 5'd0, 0);
    mix(1, 0, 32'hAB0, JALR, 5'd0, 5'd1, 0, ADD,  5'd0, 5'd0, 0);
    idle();

    // Reset in the middle of activity clears stack and shadow.
    dec(32'hB00, JAL, 5'd1, 5'd0); exe(32'hB00, JAL, 5'd1, 5'd0); tick();
    dec(32'hB10, JAL, 5'd1, 5'd0); tick();
    rst_n = 0; flush = 1; tick();
    rst_n = 1; idle(); tick();
    chk("midrst_cnt", m_cnt, 0);
    dec(32'hC00, JALR, 5'd0, 5'd1);
    lit("midrst_ret", 1'b0, 32'h0);
    tick();
    idle(); flush = 1; tick();
    idle(); dec(32'hC10, JALR, 5'd0, 5'd1);
    lit("midrst_flush_ret", 1'b0, 32'h0);
    tick();
    idle(); tick();

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
